// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and constants for the execute-stage shifters.
//               Holds the right-shifter FSM state type, the per-cycle step
//               limit and the default datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Default datapath widths shared with the other execute units
    localparam int unsigned SHR_WIDTH   = 64;
    localparam int unsigned SHR_SHAMT_W = 6;
    localparam int unsigned SHR_TAG_W   = 5;

    // Largest number of bit positions retired in one cycle
    localparam int unsigned SHR_MAX_STEP = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } shr_state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_right_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_step
// Description : One combinational right-shift step of one or two bit
//               positions, filling vacated MSBs with a supplied fill bit.
// Ports       : data     - value to shift
//               fill     - bit inserted at the MSB end
//               two_bits - 1 = shift by two, 0 = shift by one
//               shifted  - result
// Revision    : 1.0 - initial release
// ============================================================================
module shift_right_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = SHR_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
    input  logic             two_bits,
    output logic [WIDTH-1:0] shifted
);

    assign shifted = two_bits ? {fill, fill, data[WIDTH-1:2]}
                              : {fill, data[WIDTH-1:1]};

endmodule : shift_right_step
`default_nettype wire

// File: rtl/seq_shift_right.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_right
// Description : Multi-cycle logical/arithmetic right shifter (LSR/ASR).
//               Accepts one tagged operation over a valid/ready handshake,
//               retires up to two bit positions per cycle and returns the
//               result with its tag over a second valid/ready handshake.
//               Flush drops any in-flight or unconsumed result.
// Ports       : clk, reset (sync, active-high), flush
//               in_valid/in_ready, in_arith, in_operand, in_shamt, in_tag
//               out_valid/out_ready, out_result, out_tag
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_right
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = SHR_WIDTH,
    parameter int unsigned SHAMT_W = SHR_SHAMT_W,
    parameter int unsigned TAG_W   = SHR_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_arith,
    input  logic [WIDTH-1:0]   in_operand,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam logic [SHAMT_W-1:0] c_max_step = SHAMT_W'(SHR_MAX_STEP);

    shr_state_t          r_state;
    shr_state_t          w_state_next;
    logic [WIDTH-1:0]    r_data;
    logic [TAG_W-1:0]    r_tag;
    logic [SHAMT_W-1:0]  r_rem;
    logic                r_fill;

    logic                w_accept;
    logic                w_two;
    logic [SHAMT_W-1:0]  w_step;
    logic [SHAMT_W-1:0]  w_rem_next;
    logic [WIDTH-1:0]    w_shifted;

    assign in_ready   = (r_state == IDLE) && !reset;
    assign out_valid  = (r_state == DONE);
    assign out_result = r_data;
    assign out_tag    = r_tag;

    assign w_accept   = in_valid && in_ready && !flush;

    // Step never exceeds the remaining count, so no over-shift is possible
    assign w_two      = (r_rem >= c_max_step);
    assign w_step     = w_two ? c_max_step : SHAMT_W'(1);
    assign w_rem_next = r_rem - w_step;

    shift_right_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .data     (r_data),
        .fill     (r_fill),
        .two_bits (w_two),
        .shifted  (w_shifted)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides the handshake in every state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (in_shamt == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_rem_next == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (flush) begin
            w_state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers. The fill bit is captured once at accept so the
    // sign never comes from partially shifted data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_tag  <= '0;
            r_rem  <= '0;
            r_fill <= 1'b0;
        end else if (w_accept) begin
            r_data <= in_operand;
            r_tag  <= in_tag;
            r_rem  <= in_shamt;
            r_fill <= in_arith & in_operand[WIDTH-1];
        end else if ((r_state == BUSY) && !flush) begin
            r_data <= w_shifted;
            r_rem  <= w_rem_next;
        end
    end

endmodule : seq_shift_right
`default_nettype wire

// File: tb/tb_seq_shift_right.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_right
// Description : Directed self-checking bench for seq_shift_right.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_right;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_arith;
    logic [63:0] in_operand;
    logic [5:0]  in_shamt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    int checks;
    int failures;

    seq_shift_right dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_arith   (in_arith),
        .in_operand (in_operand),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op for one edge; on return the bench is in cycle 1
    task automatic issue(input logic arith, input logic [63:0] op,
                         input logic [5:0] sh, input logic [4:0] tg);
        in_valid   = 1'b1;
        in_arith   = arith;
        in_operand = op;
        in_shamt   = sh;
        in_tag     = tg;
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid   = 1'b0;
        in_operand = '0;
        in_shamt   = '0;
        in_tag     = '0;
        in_arith   = 1'b0;
    endtask

    // Wait (bounded) for out_valid; returns the cycle it was first seen
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_consume", 64'(out_valid), 64'd0);
        chk("in_ready_after_consume", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string name, input logic arith, input logic [63:0] op,
                          input logic [5:0] sh, input logic [4:0] tg,
                          input logic [63:0] exp_res, input int exp_cyc);
        int cyc;
        issue(arith, op, sh, tg);
        wait_valid(cyc);
        chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
        chk({name, "_result"}, out_result, exp_res);
        chk({name, "_tag"}, 64'(out_tag), 64'(tg));
        consume();
    endtask

    initial begin
        int cyc;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_arith   = 1'b0;
        in_operand = '0;
        in_shamt   = '0;
        in_tag     = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", out_result, 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Logical shift
        run_op("lsr4", 1'b0, 64'h34ce589123be64ac, 6'd4, 5'h0A, 64'h034ce589123be64a, 3);
        // Arithmetic shifts and sign fill
        run_op("asr5", 1'b1, 64'h8000000000000000, 6'd5, 5'h01, 64'hFC00000000000000, 4);
        run_op("lsr63", 1'b0, 64'h8000000000000000, 6'd63, 5'h02, 64'h0000000000000001, 33);
        run_op("asr63", 1'b1, 64'h8000000000000000, 6'd63, 5'h03, 64'hFFFFFFFFFFFFFFFF, 33);
        run_op("asr7_neg", 1'b1, 64'hF0000000000000F0, 6'd7, 5'h1F, 64'hFFE0000000000001, 5);
        run_op("asr3_pos", 1'b1, 64'h7000000000000000, 6'd3, 5'h11, 64'h0E00000000000000, 3);
        run_op("lsr1", 1'b0, 64'h0000000000000003, 6'd1, 5'h04, 64'h0000000000000001, 2);

        // Zero shift, then backpressure for 3 cycles
        issue(1'b0, 64'h1234, 6'd0, 5'h15);
        chk("zero_out_valid_c1", 64'(out_valid), 64'd1);
        chk("zero_in_ready_c1", 64'(in_ready), 64'd0);
        chk("zero_result", out_result, 64'h1234);
        chk("zero_tag", 64'(out_tag), 64'h15);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", out_result, 64'h1234);
            chk("bp_tag", 64'(out_tag), 64'h15);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        consume();

        // Flush in cycle 2 of LSR by 20
        issue(1'b0, 64'hFFFF_0000_FFFF_0000, 6'd20, 5'h07);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_in_ready_c3", 64'(in_ready), 64'd1);
        cyc = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) cyc++;
            tick();
        end
        chk("flush_busy_no_out_valid", 64'(cyc), 64'd0);

        // Flush with in_valid in IDLE: no accept
        in_valid   = 1'b1;
        in_operand = 64'h55;
        in_shamt   = 6'd0;
        flush      = 1'b1;
        tick();
        in_valid   = 1'b0;
        flush      = 1'b0;
        chk("flush_idle_no_accept_valid", 64'(out_valid), 64'd0);
        chk("flush_idle_in_ready", 64'(in_ready), 64'd1);

        run_op("after_flush", 1'b0, 64'hF0, 6'd4, 5'h08, 64'hF, 3);

        // Flush coinciding with out_ready in DONE
        issue(1'b0, 64'hAA, 6'd2, 5'h09);
        wait_valid(cyc);
        chk("fd_latency", 64'(cyc), 64'd2);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) cyc++;
            tick();
        end
        chk("flush_done_no_out_valid", 64'(cyc), 64'd0);
        chk("flush_done_in_ready", 64'(in_ready), 64'd1);

        // Reset mid-operation
        issue(1'b1, 64'h8000_0000_0000_1234, 6'd20, 5'h1C);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out_result", out_result, 64'd0);
        chk("rst_mid_out_tag", 64'(out_tag), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) cyc++;
            if (i < 11) tick();
        end
        chk("rst_mid_no_result", 64'(cyc), 64'd0);
        run_op("after_reset", 1'b1, 64'h8000000000000000, 6'd5, 5'h12, 64'hFC00000000000000, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_shift_right
`default_nettype wire

// File: doc/seq_shift_right.md
Name: seq_shift_right

Overview:
- Multi-cycle logical/arithmetic right-shift functional unit for the execute stage (LSR/ASR).
- It is the right-shift counterpart to the fixed left shifter in the address path.
- Accepts one tagged operation per transaction over a valid/ready handshake and retires 1 or 2 bit positions per cycle.
- Returns the result with its tag over a valid/ready handshake, and drops in-flight work on flush.

Parameters:
- WIDTH, 64, operand/result width in bits.
- SHAMT_W, 6, shift-amount width; equals clog2(WIDTH).
- TAG_W, 5, width of the reorder tag carried alongside the operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of any in-flight or completed-but-unconsumed operation.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high only in IDLE with reset low.
- in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- in_operand  input  WIDTH  value to shift.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_tag  input  TAG_W  tag, returned unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_result  output  WIDTH  shifted value.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- States are IDLE, BUSY and DONE.
- Reset: state=IDLE, out_valid=0, out_result=0, out_tag=0, internal remaining count=0, fill bit=0. in_ready=0 while reset is high. Reset overrides everything, including mid-operation; no result is ever emitted for an interrupted op.
- Accept: on a rising edge where in_valid && in_ready && !flush:
  - latch operand, tag, shamt as remaining count;
  - fill bit = in_arith & in_operand[WIDTH-1];
  - next state = DONE if shamt==0, else BUSY.
- BUSY, each cycle:
  - step s = 2 if remaining>=2, else 1;
  - data = {s fill bits, data[WIDTH-1:s]};
  - remaining -= s;
  - if remaining becomes 0, next state = DONE.
- Latency: accept in cycle 0 -> out_valid high in cycle 1+ceil(shamt/2). shamt=0 -> cycle 1; shamt=63 -> cycle 33.
- DONE:
  - out_valid=1; out_result/out_tag hold stable until out_ready.
  - out_valid && out_ready -> IDLE next cycle, out_valid low.
  - No accept in the same cycle; the unit is not pipelined.
- out_result/out_tag retain their last values in IDLE. Consumers must qualify them with out_valid.
- Flush:
  - in BUSY or DONE -> IDLE next cycle, out_valid=0;
  - the same-cycle handshake on out_ready is ignored (result discarded);
  - flush with in_valid in IDLE -> no accept.
- Priority: reset > flush > handshake.
- Width rules:
  - shift count is never larger than remaining, so no over-shift;
  - fill is sampled once at accept, never from partially shifted data.

Decomposition:
- shift_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} shr_state_t;
  - localparam SHR_MAX_STEP = 2;
  - the default WIDTH/SHAMT_W/TAG_W constants shared with the other execute units.
- One combinational sub-module, shift_right_step: inputs data[WIDTH], fill, two_bits; output shifted data.
- The top holds the FSM, counter, registers and handshake.

Test Plan:
- Logical shift: LSR of 64'h34ce589123be64ac by 4, tag 5'h0A -> out_result 64'h034ce589123be64a, out_tag 0A, out_valid in cycle 3.
- Arithmetic shift and sign fill:
  - ASR of 64'h8000000000000000 by 5 -> 64'hFC00000000000000, out_valid in cycle 4.
  - Same operand with LSR by 63 -> 64'h0000000000000001 in cycle 33.
  - ASR by 63 -> 64'hFFFFFFFFFFFFFFFF.
- Zero shift: shamt=0, operand 64'h1234 -> 64'h1234 in cycle 1; in_ready low in cycles 1 and later until consumed.
- Backpressure: out_ready held low for 3 cycles after out_valid -> out_result/out_tag unchanged, in_ready=0. out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Flush:
  - flush in cycle 2 of LSR by 20 -> IDLE in cycle 3, no out_valid ever, then a new op (LSR 64'hF0 by 4) returns 64'hF correctly;
  - flush coinciding with out_ready in DONE -> no further out_valid.
- Reset mid-operation: reset for 1 cycle during BUSY -> next cycle out_valid=0, out_result=0, out_tag=0, in_ready=1 after reset deasserts. A back-to-back op after reset completes with the correct latency.
